// File: rtl/fifo_frame_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_frame_reader_pkg
// Shared definitions for the FIFO frame reader: FSM state encoding, header
// size and the default largest accepted payload length.
// -----------------------------------------------------------------------------
package fifo_frame_reader_pkg;

  // Frame parser states. The state at the time a word returns from the FIFO
  // decides what that word means.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // next returned word is length[15:8]
    ST_LEN_LO  = 2'd1,  // next returned word is length[7:0]
    ST_PAYLOAD = 2'd2,  // returned words are forwarded downstream
    ST_DROP    = 2'd3   // returned words are discarded (oversized frame)
  } state_e;

  // Big-endian length header size in bytes.
  localparam int LEN_BYTES = 2;

  // Largest payload accepted by default (Ethernet-style frame limit).
  localparam int DEFAULT_MAX_LEN = 1522;

endpackage

// File: rtl/fifo_frame_reader_skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Two-entry FIFO that decouples the FIFO read pipeline from downstream
// backpressure. The head entry is presented combinationally; a pop and a push
// in the same cycle leave the count unchanged.
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset (empties the buffer)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        remove the head entry (ignored when empty)
//   head_data_o  head entry, all zeros when empty
//   head_valid_o buffer holds at least one entry
//   count_o      number of entries held (0..2)
// -----------------------------------------------------------------------------
module skid_buffer
  import fifo_frame_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_en;
  logic             pop_en;

  assign head_valid_o = (count_q != 2'd0);
  assign pop_en       = pop_i && head_valid_o;
  // A push into a full buffer is only accepted when the head leaves this cycle.
  assign push_en      = push_i && ((count_q != 2'd2) || pop_en);

  // NOTE: the storage array has no reset; it is never observed while empty
  // because the head is forced to zero whenever count_q is zero.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = head_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// fifo_frame_reader
// Drains length-prefixed frames (2-byte big-endian length, then payload) from
// the read side of a FIFO and presents the payload as a valid/ready byte
// stream with an end-of-frame marker. Zero-length and oversized headers are
// rejected with a one-cycle frame_err pulse; oversized payloads are skipped.
//
// Ports
//   rclk           FIFO read clock, the only clock
//   reset          synchronous active-low reset
//   fifo_occu_out  FIFO occupancy in words
//   read_data_out  FIFO read data, valid the cycle after read_enable
//   read_enable    FIFO pop request, one word per asserted cycle
//   out_data       payload byte
//   out_valid      out_data is valid
//   out_last       out_data is the final payload byte of its frame
//   out_ready      downstream accepts the byte when out_valid && out_ready
//   frame_err      one-cycle pulse on a rejected header
//   busy           parser is not in IDLE
// -----------------------------------------------------------------------------
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_LEN    = DEFAULT_MAX_LEN
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   fifo_occu_out,
  input  logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int            LEN_W     = LEN_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  state_e            state_q;
  logic              rd_inflight_q;
  logic [LEN_W-1:0]  length_q;
  logic [LEN_W-1:0]  byte_cnt_q;
  logic              frame_err_q;

  logic [LEN_W-1:0]  hdr_len;
  logic              count_done;
  logic              sb_push;
  logic              sb_pop;
  logic              sb_valid;
  logic [1:0]        sb_count;
  logic [1:0]        sb_free;
  logic [DATA_WIDTH:0] sb_head;
  logic              fifo_has_word;
  logic              room_for_word;

  // Full length as it becomes known in LEN_LO: stored high byte plus the
  // low byte returning this cycle.
  assign hdr_len    = {length_q[LEN_W-1:8], read_data_out};
  // Final payload (or dropped) word of the current frame.
  assign count_done = (byte_cnt_q == length_q - LEN_W'(1));

  assign sb_push = rd_inflight_q && (state_q == ST_PAYLOAD);
  assign sb_pop  = sb_valid && out_ready;

  // A slot being vacated by this cycle's handshake counts as free, which is
  // what lets the pipeline sustain one byte per cycle with out_ready high.
  assign sb_free = 2'd2 - sb_count + {1'b0, sb_pop};

  // The occupancy does not yet reflect last cycle's pop, and last cycle's
  // word still needs a slot, so both are discounted by the in-flight read.
  assign fifo_has_word = fifo_occu_out > (ADDR_WIDTH + 1)'(rd_inflight_q);
  assign room_for_word = sb_free > {1'b0, rd_inflight_q};
  assign read_enable   = reset && fifo_has_word && room_for_word;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge rclk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rd_inflight_q <= 1'b0;
      length_q      <= '0;
      byte_cnt_q    <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      rd_inflight_q <= read_enable;
      frame_err_q   <= 1'b0;
      if (rd_inflight_q) begin
        case (state_q)
          ST_IDLE: begin
            length_q[LEN_W-1:8] <= read_data_out;
            state_q             <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            length_q[7:0] <= read_data_out;
            byte_cnt_q    <= '0;
            if (hdr_len == '0) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else if (hdr_len > MAX_LEN_W) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_DROP;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD, ST_DROP: begin
            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            if (count_done) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i       (rclk),
    .rst_ni      (reset),
    .push_i      (sb_push),
    .push_data_i ({count_done, read_data_out}),
    .pop_i       (sb_pop),
    .head_data_o (sb_head),
    .head_valid_o(sb_valid),
    .count_o     (sb_count)
  );

  assign out_data  = sb_head[DATA_WIDTH-1:0];
  assign out_last  = sb_head[DATA_WIDTH];
  assign out_valid = sb_valid;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_frame_reader
// Drives fifo_frame_reader from a behavioural FIFO model and checks the output
// byte stream against a queue of expected {last, data} entries.
// -----------------------------------------------------------------------------
module tb_fifo_frame_reader;

  logic       rclk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] fifo_occu_out = '0;
  logic [7:0] read_data_out = '0;
  logic       read_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fifo_frame_reader dut (
    .rclk         (rclk),
    .reset        (reset),
    .fifo_occu_out(fifo_occu_out),
    .read_data_out(read_data_out),
    .read_enable  (read_enable),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 rclk = ~rclk;

  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  // Occupancy is registered and lags the pop by one cycle, like a FIFO whose
  // read-side count is updated from a registered read pointer.
  logic [7:0] fifo_mem [0:4095];
  int wr_idx = 0;
  int rd_idx = 0;
  int underflow = 0;
  logic re_s = 1'b0;

  function automatic logic [4:0] occ_now();
    int d;
    d = wr_idx - rd_idx;
    return (d > 16) ? 5'd16 : 5'(d);
  endfunction

  always @(negedge rclk) re_s <= read_enable;

  always @(posedge rclk) begin
    if (!reset) begin
      rd_idx        <= wr_idx;
      fifo_occu_out <= '0;
    end else begin
      fifo_occu_out <= occ_now();
      if (re_s) begin
        if (wr_idx == rd_idx) begin
          underflow <= underflow + 1;
        end else begin
          read_data_out <= fifo_mem[rd_idx % 4096];
          rd_idx        <= rd_idx + 1;
        end
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0
  int ready_cnt  = 0;
  always @(posedge rclk) begin
    #1;
    ready_cnt = ready_cnt + 1;
    if (ready_mode == 1) out_ready = ((ready_cnt % 3) == 0);
    else                 out_ready = 1'b1;
  end

  // ---------------- output monitor ----------------
  logic [8:0] obs_data [0:255];
  int         obs_cyc  [0:255];
  int         obs_wr = 0;
  int         err_cycles = 0;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_head = '0;

  always @(negedge rclk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || {out_last, out_data} != prev_head))
        stall_viol = stall_viol + 1;
      if (out_valid && out_ready) begin
        obs_data[obs_wr % 256] = {out_last, out_data};
        obs_cyc[obs_wr % 256]  = cyc;
        obs_wr = obs_wr + 1;
      end
      if (frame_err) err_cycles = err_cycles + 1;
      prev_stall = out_valid && !out_ready;
      prev_head  = {out_last, out_data};
    end
  end

  // ---------------- scoreboard helpers ----------------
  logic [8:0] exp_q [$];
  int obs_rd = 0;
  int cyc_got [0:7];

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    fifo_mem[wr_idx % 4096] = b;
    wr_idx = wr_idx + 1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic compare_obs(input int n, input int budget, input string name);
    int waited;
    logic [8:0] got, want;
    waited = 0;
    while ((obs_wr - obs_rd) < n && waited < budget) begin
      tick();
      waited++;
    end
    if ((obs_wr - obs_rd) < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required %0d", name, obs_wr - obs_rd, n);
      exp_q.delete();
      obs_rd = obs_wr;
      return;
    end
    for (int i = 0; i < n; i++) begin
      got = obs_data[obs_rd % 256];
      cyc_got[i] = obs_cyc[obs_rd % 256];
      obs_rd++;
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s byte %0d: got last=%0b data=%02h, required last=%0b data=%02h",
                 name, i, got[8], got[7:0], want[8], want[7:0]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({read_enable, out_valid, out_last, out_data, frame_err, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got re=%0b v=%0b l=%0b d=%02h err=%0b busy=%0b, required all 0",
               read_enable, out_valid, out_last, out_data, frame_err, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({read_enable, out_valid, busy} !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got re=%0b v=%0b busy=%0b, required 0",
               read_enable, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    send(8'h00); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    expect_byte(8'hAA, 1'b0); expect_byte(8'hBB, 1'b0); expect_byte(8'hCC, 1'b1);
    compare_obs(3, 100, "basic");
    checks++;
    if ((cyc_got[1] - cyc_got[0]) != 1 || (cyc_got[2] - cyc_got[1]) != 1) begin
      errors++;
      $display("FAIL basic_throughput: got gaps %0d,%0d, required 1,1",
               cyc_got[1] - cyc_got[0], cyc_got[2] - cyc_got[1]);
    end
    repeat (4) tick();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: got busy=%0b valid=%0b, required 0,0", busy, out_valid);
    end
  endtask

  task automatic test_stall();
    ready_mode = 1;
    send(8'h00); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
    expect_byte(8'hAA, 1'b0); expect_byte(8'hBB, 1'b0); expect_byte(8'hCC, 1'b1);
    compare_obs(3, 200, "stall");
    repeat (6) tick();
    ready_mode = 0;
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d violations, required 0", stall_viol);
    end
    checks++;
    if (obs_wr != obs_rd) begin
      errors++;
      $display("FAIL stall_extra: got %0d extra bytes, required 0", obs_wr - obs_rd);
    end
    checks++;
    if (underflow != 0) begin
      errors++;
      $display("FAIL stall_underflow: got %0d underflows, required 0", underflow);
    end
  endtask

  task automatic test_zero_len();
    int err0;
    err0 = err_cycles;
    send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h5A);
    expect_byte(8'h5A, 1'b1);
    compare_obs(1, 100, "zero_len");
    repeat (3) tick();
    checks++;
    if ((err_cycles - err0) != 1) begin
      errors++;
      $display("FAIL zero_len_err: got %0d frame_err cycles, required 1", err_cycles - err0);
    end
  endtask

  task automatic test_drop();
    int err0;
    err0 = err_cycles;
    send(8'h06); send(8'h00);
    for (int i = 0; i < 1536; i++) send(8'(i));
    send(8'h00); send(8'h01); send(8'h77);
    expect_byte(8'h77, 1'b1);
    compare_obs(1, 4000, "drop");
    repeat (3) tick();
    checks++;
    if ((err_cycles - err0) != 1) begin
      errors++;
      $display("FAIL drop_err: got %0d frame_err cycles, required 1", err_cycles - err0);
    end
    checks++;
    if (obs_wr != obs_rd || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_tail: got %0d extra bytes busy=%0b, required 0,0", obs_wr - obs_rd, busy);
    end
  endtask

  task automatic test_back_to_back();
    send(8'h00); send(8'h02); send(8'h11); send(8'h22);
    send(8'h00); send(8'h01); send(8'h33);
    expect_byte(8'h11, 1'b0); expect_byte(8'h22, 1'b1); expect_byte(8'h33, 1'b1);
    compare_obs(3, 100, "b2b");
    checks++;
    if ((cyc_got[1] - cyc_got[0]) != 1 || (cyc_got[2] - cyc_got[1]) > 3) begin
      errors++;
      $display("FAIL b2b_gap: got spacing %0d,%0d, required 1,<=3",
               cyc_got[1] - cyc_got[0], cyc_got[2] - cyc_got[1]);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    send(8'h00); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    expect_byte(8'h01, 1'b0); expect_byte(8'h02, 1'b0);
    waited = 0;
    while ((obs_wr - obs_rd) < 2 && waited < 100) begin
      tick();
      waited++;
    end
    reset = 1'b0;
    compare_obs(2, 10, "mid_pre");
    repeat (2) tick();
    checks++;
    if ({read_enable, out_valid, out_last, out_data, frame_err, busy} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got re=%0b v=%0b l=%0b d=%02h err=%0b busy=%0b, required all 0",
               read_enable, out_valid, out_last, out_data, frame_err, busy);
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs_wr != obs_rd) begin
      errors++;
      $display("FAIL mid_abandon: got %0d stray bytes, required 0", obs_wr - obs_rd);
    end
    send(8'h00); send(8'h01); send(8'hEE);
    expect_byte(8'hEE, 1'b1);
    compare_obs(1, 100, "mid_post");
    checks++;
    if (underflow != 0) begin
      errors++;
      $display("FAIL final_underflow: got %0d underflows, required 0", underflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO word width; only 8 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, FIFO address width; occupancy is ADDR_WIDTH+1 bits.
REQ-003 SHALL have parameter MAX_LEN, default 1522, largest accepted payload length in bytes.
REQ-004 rclk  input  1  sole clock, the FIFO read clock; one clock, all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 fifo_occu_out  input  ADDR_WIDTH+1  FIFO read-side occupancy in words.
REQ-007 read_data_out  input  DATA_WIDTH  FIFO read data, valid one cycle after read_enable.
REQ-008 read_enable  output  1  FIFO pop request, one word per asserted cycle.
REQ-009 out_data  output  DATA_WIDTH  payload byte.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_last  output  1  qualifies the final payload byte of a frame.
REQ-012 out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
REQ-013 frame_err  output  1  one-cycle pulse on a rejected header.
REQ-014 busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-015 SHALL drain frames formatted as: length high byte, length low byte (big-endian payload length), then exactly that many payload bytes.
REQ-016 SHALL assert read_enable only when fifo_occu_out > rd_inflight and free skid slots > rd_inflight.
- rd_inflight: 1 if read_enable was high in the previous cycle, else 0.
- Skid buffer: 2 entries.
REQ-017 SHALL classify each returned word (the cycle after read_enable) by the FSM state at return time.
REQ-018 FSM states SHALL be IDLE, LEN_LO, PAYLOAD and DROP.
REQ-019 IDLE: returned word is captured as length[15:8]; go to LEN_LO.
REQ-020 LEN_LO: returned word is captured as length[7:0], with these transitions:
- length==0: pulse frame_err, go to IDLE.
- length>MAX_LEN: pulse frame_err, go to DROP.
- Otherwise: go to PAYLOAD.
REQ-021 PAYLOAD: each returned word is pushed into the skid buffer with last = (byte_cnt == length-1).
- After the last byte is pushed, go to IDLE.
REQ-022 DROP: returned words are discarded, not pushed, and counted.
- After length words, go to IDLE.
REQ-023 byte_cnt SHALL be 16 bits, cleared on entry to PAYLOAD/DROP, and incremented per returned word.
REQ-024 out_data/out_valid/out_last SHALL present the skid buffer head; the head pops on out_valid && out_ready.
REQ-025 Simultaneous push and pop SHALL be legal in the same cycle; buffer count is unchanged.
REQ-026 With out_ready held high and FIFO non-empty, steady-state throughput SHALL be one payload byte per cycle.
REQ-027 With out_ready low, prefetch SHALL stop so that the buffer plus in-flight reads never exceeds 2.
REQ-028 out_valid SHALL never deassert without a handshake, and out_data/out_last SHALL be stable while out_valid && !out_ready.
REQ-029 Header bytes of the next frame MAY be prefetched while the current frame's last byte waits in the buffer.
REQ-030 Latency SHALL be:
- Empty FIFO receiving a 2-byte header plus payload: first out_valid no earlier than 4 cycles after fifo_occu_out first becomes nonzero.
- That bound assumes occupancy rises to ≥3 at once.

Reset
REQ-031 When reset==0 at a rising edge, the following SHALL reset:
- FSM to IDLE.
- Skid buffer emptied.
- rd_inflight=0, byte_cnt=0, length=0.
REQ-032 During and after reset, outputs SHALL be read_enable=0, out_valid=0, out_last=0, out_data=0, frame_err=0, busy=0.
REQ-033 A word returning in the cycle after reset release from a pre-reset read SHALL be ignored.
REQ-034 Reset mid-frame SHALL abandon the frame; the next returned word is treated as a length high byte.

Structure
REQ-035 A shared package SHALL hold:
- The FSM state enum.
- The LEN_BYTES=2 constant.
- The default MAX_LEN.
REQ-036 The 2-entry skid buffer SHALL be a sub-module named skid_buffer (parameter DATA_WIDTH+1 for last).
REQ-037 The FSM, read scheduling and counters SHALL live in fifo_frame_reader.

Verification
REQ-038 FIFO model holds 00 03 AA BB CC, out_ready=1 -> out bytes AA,BB,CC on consecutive cycles, out_last only with CC, FSM back to IDLE, busy=0.
REQ-039 Same frame with out_ready toggling 1,0,0,1,... -> no byte lost or duplicated, data stable while stalled, fifo never underflows.
REQ-040 Header 00 00 followed by 00 01 5A -> frame_err one pulse; then single byte 5A with out_last=1.
REQ-041 Header 06 00 (1536>1522) + 1536 bytes + 00 01 77 -> frame_err one pulse, no out_valid for dropped bytes, then 77 with out_last.
REQ-042 Two back-to-back frames 00 02 11 22 00 01 33, out_ready=1 -> 11,22(last),33(last), no gap larger than 2 cycles between frames.
REQ-043 reset=0 asserted mid-PAYLOAD of 00 04 01 02 03 04 after byte 02 -> all outputs 0, busy=0; subsequent 00 01 EE yields EE with out_last.
